// File: rtl/mem_access_if.sv
// Data-memory request/grant/response bus between the MEM stage (master)
// and the data memory (slave).
interface mem_access_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// rv64IM memory-access stage: EX/MEM latch, dmem handshake FSM, store lane
// formatting and load extension. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_access (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         store_i,
  input  logic [2:0]   funct3_i,
  input  logic [63:0]  aluout_i,
  input  logic [63:0]  sdata_i,
  input  logic         wen_i,
  input  logic [4:0]   rd_i,
  input  logic [63:0]  pc_i,
  input  logic         exit_i,
  mem_access_if.master dmem,
  output logic         valid_o,
  output logic         wen_o,
  output logic [4:0]   rd_o,
  output logic [63:0]  wdata_o,
  output logic [63:0]  pc_o,
  output logic         exit_o,
  output logic         stall_req_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic         misalign_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic        r_valid, r_load, r_store, r_wen, r_exit, r_misalign;
  logic [2:0]  r_funct3;
  logic [63:0] r_aluout, r_sdata, r_pc;
  logic [4:0]  r_rd;
  logic [63:0] ld_q;

  logic        capture, in_mem, in_misalign;
  logic [2:0]  off;
  logic [7:0]  mask;
  logic [63:0] shifted, ld_fmt;

  assign capture = (state == S_IDLE) || (state == S_DONE);
  assign in_mem  = !flush_i && (load_i || store_i);
  assign off     = r_aluout[2:0];

  // Alignment is judged on the incoming EX address so the FSM can skip the bus.
  always_comb begin
    in_misalign = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    case (funct3_i[1:0])
      2'b01:   in_misalign = aluout_i[0];
      2'b10:   in_misalign = |aluout_i[1:0];
      2'b11:   in_misalign = |aluout_i[2:0];
      default: in_misalign = 1'b0;
    endcase
`endif
  end

  always_comb begin
    mask = 8'h01;
    case (r_funct3[1:0])
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
  end

  assign shifted = dmem.dmem_rdata_i >> {off, 3'b000};

  always_comb begin
    ld_fmt = shifted;
    case (r_funct3)
      3'b000:  ld_fmt = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_fmt = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_fmt = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ld_fmt = {{56{1'b0}}, shifted[7:0]};
      3'b101:  ld_fmt = {{48{1'b0}}, shifted[15:0]};
      3'b110:  ld_fmt = {{32{1'b0}}, shifted[31:0]};
      default: ld_fmt = shifted;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      r_valid    <= 1'b0;
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_wen      <= 1'b0;
      r_exit     <= 1'b0;
      r_misalign <= 1'b0;
      r_funct3   <= '0;
      r_aluout   <= '0;
      r_sdata    <= '0;
      r_pc       <= '0;
      r_rd       <= '0;
      ld_q       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (flush_i) begin
            r_valid    <= 1'b0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_wen      <= 1'b0;
            r_exit     <= 1'b0;
            r_misalign <= 1'b0;
            r_funct3   <= '0;
            r_aluout   <= '0;
            r_sdata    <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
          end else begin
            r_valid    <= 1'b1;
            r_load     <= load_i;
            r_store    <= store_i;
            r_wen      <= wen_i;
            r_exit     <= exit_i;
            r_misalign <= in_mem && in_misalign;
            r_funct3   <= funct3_i;
            r_aluout   <= aluout_i;
            r_sdata    <= sdata_i;
            r_pc       <= pc_i;
            r_rd       <= rd_i;
          end
          if (in_mem) state <= in_misalign ? S_DONE : S_REQ;
          else        state <= S_IDLE;
        end
        S_REQ: begin
          if (dmem.dmem_gnt_i) state <= r_store ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (dmem.dmem_rvalid_i) begin
            ld_q  <= ld_fmt;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_req_o       = (state == S_REQ) || (state == S_WAIT);
  assign dmem.dmem_req_o   = (state == S_REQ);
  assign dmem.dmem_we_o    = r_store;
  assign dmem.dmem_addr_o  = {r_aluout[63:3], 3'b000};
  assign dmem.dmem_wdata_o = r_sdata << {off, 3'b000};
  assign dmem.dmem_wstrb_o = (r_load || r_store) ? (mask << off) : '0;

  assign valid_o = r_valid &&
                   (((state == S_IDLE) && !(r_load || r_store)) || (state == S_DONE));
  assign wdata_o = r_load ? ld_q : r_aluout;
  assign wen_o   = valid_o && r_wen && !r_store && !r_misalign;
  assign exit_o  = valid_o && r_exit;
  assign rd_o    = r_rd;
  assign pc_o    = r_pc;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o = (state == S_DONE) && r_misalign;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: writeback bundles are scoreboarded, bus
// handshakes are driven with configurable grant/response delays.
module tb_mem_access;
  logic        clock = 1'b0;
  logic        reset, flush_i, load_i, store_i, wen_i, exit_i;
  logic [2:0]  funct3_i;
  logic [63:0] aluout_i, sdata_i, pc_i;
  logic [4:0]  rd_i;
  logic        valid_o, wen_o, exit_o, stall_req_o;
  logic [4:0]  rd_o;
  logic [63:0] wdata_o, pc_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  always #5 clock = ~clock;

  mem_access_if dmem ();

  mem_access dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
    .aluout_i(aluout_i), .sdata_i(sdata_i), .wen_i(wen_i), .rd_i(rd_i),
    .pc_i(pc_i), .exit_i(exit_i), .dmem(dmem),
    .valid_o(valid_o), .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o),
    .pc_o(pc_o), .exit_o(exit_o), .stall_req_o(stall_req_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic        ex;
    logic        mis;
    bit          chk_data;
  } wb_t;

  wb_t         sb[$];
  wb_t         mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] sd,
                       input logic wen, input logic [4:0] rd,
                       input logic [63:0] pc, input logic ex);
    flush_i = 1'b0; load_i = ld; store_i = st; funct3_i = f3;
    aluout_i = addr; sdata_i = sd; wen_i = wen; rd_i = rd; pc_i = pc; exit_i = ex;
  endtask

  task automatic idle();
    flush_i = 1'b1; load_i = 1'b0; store_i = 1'b0; wen_i = 1'b0; exit_i = 1'b0;
  endtask

  task automatic push(input logic wen, input logic [4:0] rd, input logic [63:0] wdata,
                      input logic [63:0] pc, input logic ex, input logic mis,
                      input bit chk_data);
    wb_t e;
    e.wen = wen; e.rd = rd; e.wdata = wdata; e.pc = pc;
    e.ex = ex; e.mis = mis; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  // Plays the memory side until the stage stops stalling; rdly counts WAIT cycles.
  task automatic run_bus(input int gdly, input int rdly, input logic [63:0] rdata,
                         output int stalls, output int reqs);
    int gcnt, rcnt;
    bit done;
    stalls = 0; reqs = 0; gcnt = 0; rcnt = 0; done = 0;
    for (int c = 0; c < 64; c++) begin
      if (stall_req_o !== 1'b1) begin
        done = 1;
        break;
      end
      stalls++;
      if (dmem.dmem_req_o === 1'b1) begin
        reqs++;
        if (gcnt == gdly) begin
          dmem.dmem_gnt_i = 1'b1;
          bus_addr  = dmem.dmem_addr_o;
          bus_wdata = dmem.dmem_wdata_o;
          bus_wstrb = dmem.dmem_wstrb_o;
          bus_we    = dmem.dmem_we_o;
        end
        gcnt++;
      end else begin
        rcnt++;
        if (rcnt == rdly) begin
          dmem.dmem_rvalid_i = 1'b1;
          dmem.dmem_rdata_i  = rdata;
        end
      end
      tick();
      dmem.dmem_gnt_i    = 1'b0;
      dmem.dmem_rvalid_i = 1'b0;
      dmem.dmem_rdata_i  = 64'hA5A5_A5A5_A5A5_A5A5;
    end
    chk("bus_timeout", done, 1'b1);
  endtask

  always @(negedge clock) begin
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_valid", valid_o, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_wen", wen_o, mon_e.wen);
        chk("wb_rd", rd_o, mon_e.rd);
        chk("wb_pc", pc_o, mon_e.pc);
        chk("wb_exit", exit_o, mon_e.ex);
        if (mon_e.chk_data) chk("wb_wdata", wdata_o, mon_e.wdata);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("wb_misalign", misalign_o, mon_e.mis);
`endif
      end
    end
  end

  initial begin
    int stalls, reqs;
    reset = 1'b1;
    idle();
    funct3_i = '0; aluout_i = '0; sdata_i = '0; rd_i = '0; pc_i = '0;
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = '0;
    tick();
    tick();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_stall", stall_req_o, 1'b0);
    chk("rst_req", dmem.dmem_req_o, 1'b0);
    chk("rst_wstrb", dmem.dmem_wstrb_o, 8'h00);
    chk("rst_wdata", wdata_o, 64'h0);
    chk("rst_pc", pc_o, 64'h0);
    reset = 1'b0;
    tick();

    // ALU passthrough
    drive(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 1'b1, 5'd5, 64'h100, 1'b0);
    push(1'b1, 5'd5, 64'h1234, 64'h100, 1'b0, 1'b0, 1);
    tick();
    idle();
    chk("alu_valid", valid_o, 1'b1);
    chk("alu_stall", stall_req_o, 1'b0);
    chk("alu_req", dmem.dmem_req_o, 1'b0);
    tick();
    chk("alu_bubble_valid", valid_o, 1'b0);

    drive(1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 1'b0, 5'd0, 64'h104, 1'b1);
    push(1'b0, 5'd0, 64'h77, 64'h104, 1'b1, 1'b0, 1);
    tick();
    idle();
    tick();

    // LB / LBU at 0x1003
    drive(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 1'b1, 5'd7, 64'h120, 1'b0);
    push(1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 64'h120, 1'b0, 1'b0, 1);
    tick();
    idle();
    run_bus(0, 1, 64'h0000_0000_8000_0000, stalls, reqs);
    chk("lb_stalls", stalls, 2);
    chk("lb_addr", bus_addr, 64'h1000);
    chk("lb_we", bus_we, 1'b0);
    tick();

    drive(1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 1'b1, 5'd8, 64'h124, 1'b0);
    push(1'b1, 5'd8, 64'h80, 64'h124, 1'b0, 1'b0, 1);
    tick();
    idle();
    run_bus(0, 1, 64'h0000_0000_8000_0000, stalls, reqs);
    chk("lbu_stalls", stalls, 2);
    tick();

    // SH at 0x2006; wen_i high must not reach wen_o for a store
    drive(1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 1'b1, 5'd4, 64'h128, 1'b0);
    push(1'b0, 5'd4, 64'h2006, 64'h128, 1'b0, 1'b0, 1);
    tick();
    idle();
    run_bus(0, 1, 64'h0, stalls, reqs);
    chk("sh_stalls", stalls, 1);
    chk("sh_wstrb", bus_wstrb, 8'hC0);
    chk("sh_wdata", bus_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_addr", bus_addr, 64'h2000);
    chk("sh_we", bus_we, 1'b1);
    tick();

    // SW at 0x6004 with one extra grant wait cycle
    drive(1'b0, 1'b1, 3'b010, 64'h6004, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 5'd0, 64'h12C, 1'b0);
    push(1'b0, 5'd0, 64'h6004, 64'h12C, 1'b0, 1'b0, 1);
    tick();
    idle();
    run_bus(1, 1, 64'h0, stalls, reqs);
    chk("sw_stalls", stalls, 2);
    chk("sw_wstrb", bus_wstrb, 8'hF0);
    chk("sw_wdata", bus_wdata, 64'hCAFE_F00D_0000_0000);
    tick();

    // LH and LWU lane extraction
    drive(1'b1, 1'b0, 3'b001, 64'h7002, 64'h0, 1'b1, 5'd10, 64'h130, 1'b0);
    push(1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_F234, 64'h130, 1'b0, 1'b0, 1);
    tick();
    idle();
    run_bus(0, 1, 64'h0000_0000_F234_0000, stalls, reqs);
    tick();
    drive(1'b1, 1'b0, 3'b110, 64'h7004, 64'h0, 1'b1, 5'd11, 64'h134, 1'b0);
    push(1'b1, 5'd11, 64'h0000_0000_89AB_CDEF, 64'h134, 1'b0, 1'b0, 1);
    tick();
    idle();
    run_bus(0, 1, 64'h89AB_CDEF_0000_0000, stalls, reqs);
    tick();

    // Delayed LD; next EX op held at the inputs for the whole stall
    drive(1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 1'b1, 5'd12, 64'h200, 1'b0);
    push(1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 64'h200, 1'b0, 1'b0, 1);
    tick();
    drive(1'b0, 1'b0, 3'b000, 64'h55, 64'h0, 1'b1, 5'd9, 64'h210, 1'b0);
    push(1'b1, 5'd9, 64'h55, 64'h210, 1'b0, 1'b0, 1);
    run_bus(2, 3, 64'h0123_4567_89AB_CDEF, stalls, reqs);
    chk("ld_delay_stalls", stalls, 6);
    chk("ld_delay_reqs", reqs, 3);
    tick();
    idle();
    chk("held_op_valid", valid_o, 1'b1);
    chk("held_op_stall", stall_req_o, 1'b0);
    tick();

    // Flush while not stalled
    drive(1'b0, 1'b1, 3'b011, 64'h8000, 64'h1, 1'b1, 5'd13, 64'h300, 1'b0);
    flush_i = 1'b1;
    tick();
    idle();
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_req", dmem.dmem_req_o, 1'b0);
    chk("flush_stall", stall_req_o, 1'b0);
    tick();

    // Reset during WAIT, then a late rvalid
    drive(1'b1, 1'b0, 3'b010, 64'h5000, 64'h0, 1'b1, 5'd3, 64'h400, 1'b0);
    tick();
    idle();
    chk("rw_req", dmem.dmem_req_o, 1'b1);
    dmem.dmem_gnt_i = 1'b1;
    tick();
    dmem.dmem_gnt_i = 1'b0;
    chk("rw_wait_stall", stall_req_o, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_rst_stall", stall_req_o, 1'b0);
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dmem.dmem_rvalid_i = 1'b0;
    chk("rw_late_valid", valid_o, 1'b0);
    chk("rw_late_stall", stall_req_o, 1'b0);
    chk("rw_late_req", dmem.dmem_req_o, 1'b0);
    chk("rw_late_wdata", wdata_o, 64'h0);
    tick();
    chk("rw_idle_stall", stall_req_o, 1'b0);

    // Misaligned LW at 0x3002
`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 1'b1, 5'd14, 64'h500, 1'b0);
    push(1'b0, 5'd14, 64'h0, 64'h500, 1'b0, 1'b1, 0);
    tick();
    idle();
    chk("mis_stall", stall_req_o, 1'b0);
    chk("mis_req", dmem.dmem_req_o, 1'b0);
    chk("mis_pulse", misalign_o, 1'b1);
    tick();
    chk("mis_pulse_end", misalign_o, 1'b0);
`else
    drive(1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 1'b1, 5'd14, 64'h500, 1'b0);
    push(1'b1, 5'd14, 64'hFFFF_FFFF_8765_4321, 64'h500, 1'b0, 1'b0, 1);
    tick();
    idle();
    run_bus(0, 1, 64'h0000_8765_4321_0000, stalls, reqs);
    chk("mis_reqs", reqs, 1);
    chk("mis_wstrb", bus_wstrb, 8'h3C);
    chk("mis_addr", bus_addr, 64'h3000);
    tick();
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage between the execute stage and writeback in the rv64IM pipeline. It registers the execute outputs (EX/MEM latch) and runs a request/grant/response handshake with data memory for loads and stores. It formats store lanes and extends load data, and holds the pipeline through `stall_req_o` while a transaction is in flight. For non-memory ops it forwards the ALU result to writeback one cycle after EX.

## Interface
- No parameters (XLEN fixed at 64).
- `clock  in  1`  sole clock; all state updates on the rising edge.
- `reset  in  1`  synchronous, active-high reset.
- `flush_i  in  1`  insert a bubble instead of capturing EX outputs.
- `load_i`, `store_i`  `in  1` each  memory op class from EX.
- `funct3_i  in  3`  access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- `aluout_i  in  64`  ALU result; this is the byte address for memory ops.
- `sdata_i  in  64`  store data, right-aligned.
- `wen_i  in  1`, `rd_i  in  5`, `pc_i  in  64`, `exit_i  in  1`  writeback, debug and exit passthrough.
- `dmem_req_o  out  1`  request valid.
- `dmem_we_o  out  1`  1 = store.
- `dmem_addr_o  out  64`  address with bits [2:0] forced to 0.
- `dmem_wdata_o  out  64`  lane-shifted store data.
- `dmem_wstrb_o  out  8`  byte enables.
- `dmem_gnt_i  in  1`  request accepted.
- `dmem_rvalid_i  in  1`  load data valid.
- `dmem_rdata_i  in  64`  load data.
- `valid_o  out  1`  writeback bundle valid this cycle.
- `wen_o  out  1`, `rd_o  out  5`, `wdata_o  out  64`, `pc_o  out  64`, `exit_o  out  1`  writeback bundle; it also serves as the MEM-stage bypass source.
- `stall_req_o  out  1`  freeze upstream stages and this stage's input latch.
- `misalign_o  out  1`  misaligned-access pulse; present only with `MEM_MISALIGN_TRAP_EN`.

## Operation
- **Input latch R:** captures all EX inputs on each edge where `stall_req_o`=0.
  - If `flush_i`=1 on such an edge, R captures a bubble (valid=0, load/store/wen/exit=0).
  - `flush_i` is ignored while stalled.
- **Lane offset and data:**
  - off = R.addr[2:0].
  - `dmem_wdata_o` = R.sdata << (8·off), truncated to 64 bits.
  - `dmem_wstrb_o` = mask << off, truncated to 8 bits; mask is 0x01 for B, 0x03 for H, 0x0F for W, 0xFF for D.
  - Load result = extend(rdata >> 8·off) by funct3. B/H/W sign-extend; BU/HU/WU zero-extend; D passes through.
- **FSM states:** IDLE, REQ, WAIT, DONE.
  - IDLE: on a capture edge where R receives a load or store, go to REQ; otherwise stay.
  - REQ: `dmem_req_o`=1 and `stall_req_o`=1. When `dmem_gnt_i`=1, a store goes to DONE and a load goes to WAIT. Req, addr, we, wdata and wstrb stay stable until grant.
  - WAIT: `stall_req_o`=1. When `dmem_rvalid_i`=1, the formatted data is registered into LD and the FSM goes to DONE.
  - DONE: `stall_req_o`=0. On the next edge R captures new inputs and the FSM goes to REQ or IDLE.
  - `dmem_rvalid_i` is ignored outside WAIT. `dmem_rvalid_i` never arrives earlier than the cycle after the grant.
- **Writeback bundle:**
  - `valid_o` = R.valid & ((IDLE & !mem) | DONE).
  - `wdata_o` = LD for loads, R.aluout otherwise.
  - `wen_o` = valid_o & R.wen & !R.store.
  - `exit_o` = valid_o & R.exit.
  - `rd_o` = R.rd and `pc_o` = R.pc, always.
- **Reset:** FSM goes to IDLE, R becomes a bubble, LD is cleared. Every output reads 0 in the cycle after reset.
  - Reset during REQ or WAIT abandons the transaction; a late `dmem_rvalid_i` is dropped.

## Timing
- Non-memory op: presented at EX in cycle N, writeback valid in cycle N+1, no stall.
- Store with immediate grant: REQ in N+1, DONE in N+2. `stall_req_o` is high for exactly 1 cycle.
- Load with grant in REQ cycle N+1 and rvalid in N+2: DONE in N+3, so load-to-writeback latency is 3 cycles. `stall_req_o` is high for N+1..N+2.
- Each extra grant or response wait cycle adds exactly one stall cycle.
- `stall_req_o` is combinational from state. It never depends combinationally on `dmem_gnt_i` or `dmem_rvalid_i`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` **defined:** an access is misaligned when off is not a multiple of the access size. For a misaligned access:
  - IDLE goes directly to DONE; no bus request is issued.
  - `misalign_o`=1 for the DONE cycle.
  - `wen_o` is forced to 0.
- `MEM_MISALIGN_TRAP_EN` **undefined:** the `misalign_o` port is absent. Misaligned accesses are issued normally, and bytes shifted beyond lane 7 are dropped.

## Test plan
- **ALU passthrough:** ADD result 0x1234, rd=5, wen=1 -> next cycle valid_o=1, wdata_o=0x1234, rd_o=5, stall_req_o=0, no dmem_req_o.
- **LB:** LB at address 0x1003, rdata=0x00000000_80000000 -> wdata_o=0xFFFFFFFF_FFFFFF80. Same access as LBU -> wdata_o=0x80.
- **SH:** SH at 0x2006, sdata=0xBEEF -> wstrb=0xC0, wdata=0xBEEF0000_00000000, addr=0x2000, we=1, wen_o=0.
- **Delayed load:** LD with grant 2 cycles late and rvalid 3 cycles after grant -> stall_req_o high for exactly 6 cycles, then valid_o with LD data. The EX inputs held during the stall are captured unchanged.
- **Flush and reset:** flush_i while not stalled -> valid_o=0 next cycle. reset asserted in WAIT, then rvalid arrives -> outputs stay 0 and FSM stays IDLE.
- **Misaligned LW:** LW at 0x3002 with `MEM_MISALIGN_TRAP_EN` -> no dmem_req_o, misalign_o pulse, wen_o=0. Without the macro -> request issued with wstrb-independent load, data = rdata[47:16] sign-extended.
